// File: rtl/frame_addr_seq.sv
// frame_addr_seq: turns the camera pixel stream into framebuffer writes.
// Drives the ALU54 adder with (line base, column) and delays valid/data by the adder latency.
// Optional build macro FRAME_ADDR_CHECK_EN adds a shadow address check with a sticky addr_err output.
module frame_addr_seq #(
   parameter int unsigned H_ACTIVE    = 640,
   parameter int unsigned V_ACTIVE    = 480,
   parameter int unsigned LINE_STRIDE = 640,
   parameter int unsigned BASE_ADDR   = 0,
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned ADDER_LAT   = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              frame_start,
   input  logic              pix_valid,
   input  logic [DATA_W-1:0] pix_data,
   output logic              add_ce,
   output logic              add_reset,
   output logic [20:0]       add_a,
   output logic [10:0]       add_b,
   input  logic [21:0]       add_sum,
   output logic              wr_valid,
   output logic [21:0]       wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              frame_done,
   output logic              busy
`ifdef FRAME_ADDR_CHECK_EN
   ,
   output logic              addr_err
`endif
);

   localparam int unsigned A_W = 21;
   localparam int unsigned C_W = 11;
   localparam int unsigned S_W = 22;
   localparam int unsigned R_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

   state_t            state, state_n;
   logic [C_W-1:0]    col, col_n, ecol;
   logic [R_W-1:0]    row, row_n, erow;
   logic [A_W-1:0]    line_base, base_n, ebase;
   logic              accept;
   logic              last_px;

   logic [ADDER_LAT-1:0] vd;
   logic [ADDER_LAT-1:0] lastd;
   logic [DATA_W-1:0]    dd [ADDER_LAT];

   // Adder runs every cycle; it is only held in reset alongside this block.
   assign add_ce    = ~reset;
   assign add_reset = reset;

   // A frame_start restarts the counters in the same cycle, so its pixel is pixel 0.
   assign ecol  = frame_start ? '0 : col;
   assign erow  = frame_start ? '0 : row;
   assign ebase = frame_start ? A_W'(BASE_ADDR) : line_base;
   assign add_a = ebase;
   assign add_b = ecol;

   // Outputs come straight off the delay-line taps and the adder output register.
   assign wr_valid = vd[ADDER_LAT-1];
   assign wr_data  = dd[ADDER_LAT-1];
   assign wr_addr  = add_sum;

   // Next-state and counter update logic.
   always_comb begin
      state_n = state;
      col_n   = col;
      row_n   = row;
      base_n  = line_base;
      last_px = 1'b0;
      accept  = pix_valid & (frame_start | (state == S_ACTIVE));
      if (frame_start) begin
         state_n = S_ACTIVE;
         col_n   = '0;
         row_n   = '0;
         base_n  = A_W'(BASE_ADDR);
      end
      if (accept) begin
         if (ecol == C_W'(H_ACTIVE - 1)) begin
            col_n  = '0;
            base_n = ebase + A_W'(LINE_STRIDE);
            if (erow == R_W'(V_ACTIVE - 1)) begin
               row_n   = '0;
               state_n = S_DONE;
               last_px = 1'b1;
            end else begin
               row_n = erow + R_W'(1);
            end
         end else begin
            col_n = ecol + C_W'(1);
         end
      end
      // Leave DONE once the last pixel's marker reaches the output tap.
      if ((state == S_DONE) && !frame_start && lastd[ADDER_LAT-1]) begin
         state_n = S_IDLE;
      end
   end

   // State and counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         col       <= '0;
         row       <= '0;
         line_base <= A_W'(BASE_ADDR);
      end else begin
         state     <= state_n;
         col       <= col_n;
         row       <= row_n;
         line_base <= base_n;
      end
   end

   // Valid/data/last delay line matching the adder latency, plus done/busy flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         vd         <= '0;
         lastd      <= '0;
         frame_done <= 1'b0;
         busy       <= 1'b0;
         for (int i = 0; i < int'(ADDER_LAT); i++) dd[i] <= '0;
      end else begin
         vd[0]    <= accept;
         lastd[0] <= last_px;
         dd[0]    <= pix_data;
         for (int i = 1; i < int'(ADDER_LAT); i++) begin
            vd[i]    <= vd[i-1];
            lastd[i] <= lastd[i-1];
            dd[i]    <= dd[i-1];
         end
         frame_done <= lastd[ADDER_LAT-1];
         busy       <= (state_n == S_ACTIVE) | accept | (|ADDER_LAT'(vd << 1));
      end
   end

`ifdef FRAME_ADDR_CHECK_EN
   logic [S_W-1:0] sh [ADDER_LAT];

   // Shadow address pipeline; any disagreement with the adder result latches addr_err.
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_err <= 1'b0;
         for (int i = 0; i < int'(ADDER_LAT); i++) sh[i] <= '0;
      end else begin
         sh[0] <= S_W'(ebase) + S_W'(ecol);
         for (int i = 1; i < int'(ADDER_LAT); i++) sh[i] <= sh[i-1];
         addr_err <= addr_err | (vd[ADDER_LAT-1] & (sh[ADDER_LAT-1] != add_sum));
      end
   end
`endif

endmodule

// File: doc/frame_addr_seq.md
Name: frame_addr_seq

Overview:
- Sequencer upstream of the Gowin_ALU54 adder (mode 0: dout = a + b; AREG, BREG and OUT_REG set, so 2-cycle latency).
- Converts the OV7670 capture pixel stream into framebuffer write transactions.
- Per pixel, drives adder operands a = line base address and b = column index.
- Delays pixel data and valid by the adder latency, then emits {address, data, valid} to the PSRAM write path.

Parameters:
- H_ACTIVE, 640, pixels per line (≤ 2047).
- V_ACTIVE, 480, lines per frame.
- LINE_STRIDE, 640, address increment per line.
- BASE_ADDR, 0, frame start address (21-bit).
- DATA_W, 16, pixel data width.
- ADDER_LAT, 2, adder latency in cycles; must match the adder register configuration.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse at frame start (from vsync)
- pix_valid  in  1  pixel strobe
- pix_data  in  DATA_W  pixel value
- add_ce  out  1  adder clock enable
- add_reset  out  1  adder reset
- add_a  out  21  adder operand a (line base)
- add_b  out  11  adder operand b (column)
- add_sum  in  22  adder result
- wr_valid  out  1  write strobe
- wr_addr  out  22  write address (= add_sum)
- wr_data  out  DATA_W  write data
- frame_done  out  1  one-cycle pulse when the last pixel's write is issued
- busy  out  1  high while in ACTIVE or while writes are in flight

Behaviour:
- Reset: clk-synchronous, active-high. Outputs after reset:
  - wr_valid=0, wr_addr=0, wr_data=0, frame_done=0, busy=0.
  - add_a=BASE_ADDR, add_b=0.
  - State=IDLE, col=0, row=0, line_base=BASE_ADDR.
  - Delay pipeline valids cleared.
- add_ce = ~reset (constant 1 in operation); add_reset = reset. The pipeline advances every cycle; no stalls.
- States:
  - IDLE: pix_valid ignored. frame_start -> ACTIVE with col=0, row=0, line_base=BASE_ADDR.
  - ACTIVE: each pix_valid cycle presents add_a=line_base, add_b=col combinationally from the current counters.
    - pix_valid=1 is pushed into a valid/data delay line of depth ADDER_LAT.
    - col increments. At col==H_ACTIVE-1: col wraps to 0, line_base += LINE_STRIDE (21-bit, wraps modulo 2^21), row++.
    - At row==V_ACTIVE-1 and col==H_ACTIVE-1 with pix_valid -> DONE.
  - DONE: pix_valid ignored. Wait for the delay line to drain, then pulse frame_done for one cycle -> IDLE. frame_start in DONE -> ACTIVE immediately; frame_done still fires when the drain completes.
- Output: wr_valid/wr_data are the delay line taps at ADDER_LAT. wr_addr is add_sum, registered together with them. Latency from pix_valid to wr_valid is exactly ADDER_LAT cycles.
- Boundary cases:
  - pix_valid gaps: counters hold; add_a/add_b hold.
  - frame_start mid-frame (ACTIVE): counters restart. Writes already in the delay line still complete. No frame_done for the aborted frame.
  - frame_start and pix_valid in the same cycle: that pixel is pixel 0 of the new frame, at address BASE_ADDR.
  - Reset mid-frame: in-flight writes are discarded; wr_valid is 0 the cycle after reset.
  - busy = (state==ACTIVE) | any delay-line valid.

Optional Feature:
- Macro: FRAME_ADDR_CHECK_EN.
- Defined:
  - Keep a shadow address (line_base+col, 22-bit) delayed by ADDER_LAT.
  - Compare it against add_sum on every wr_valid.
  - Mismatch sets sticky output addr_err (1 bit); addr_err clears only on reset.
- Undefined: no shadow logic and no addr_err port; behaviour otherwise identical.

Test Plan:
- Parameters H_ACTIVE=4, V_ACTIVE=3, LINE_STRIDE=8, BASE_ADDR=0x100; frame_start, then 12 consecutive pix_valid with data 0..11. Required:
  - wr_valid 2 cycles after each pixel.
  - wr_addr sequence 0x100–0x103, 0x108–0x10B, 0x110–0x113.
  - frame_done exactly 1 cycle after the last write.
- Same frame with pix_valid every third cycle -> identical address/data sequence, each write 2 cycles after its pixel, no extra wr_valid.
- pix_valid pulses while IDLE, then 5 pixels into a frame -> no writes in IDLE. frame_start in the same cycle as pix_valid -> that pixel writes at 0x100; no frame_done for the first frame.
- Assert reset with 2 writes in flight -> wr_valid=0 the next cycle, busy=0, the following frame starts at 0x100.
- With FRAME_ADDR_CHECK_EN, force add_sum bit 0 flipped on one pixel -> addr_err rises 1 cycle later and stays high until reset. Without the flip -> addr_err stays 0.
